writeback_stage_mp: RTL and testbench

//  Parametrised multi-port writeback stage between MEM and the register file.

---
 rtl/writeback_stage_mp.sv | 170 +++++++++++++++++
 tb/tb_writeback_stage_mp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage_mp.sv
// rtl/writeback_stage_mp.sv - multi-port writeback stage with 2-entry skid queue
// Sanitises captured write enables, drains to the register file, counts retires.
module writeback_stage_mp #(
  parameter int XLEN      = 32,
  parameter int NUM_PORTS = 2,
  parameter int CNT_W     = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [NUM_PORTS-1:0]      slot_vld_i,
  input  logic [NUM_PORTS-1:0]      rd_we_i,
  input  logic [NUM_PORTS*5-1:0]    rd_addr_i,
  input  logic [NUM_PORTS*XLEN-1:0] rd_data_i,
  input  logic                      rf_stall_i,
  output logic                      out_valid_o,
  output logic [NUM_PORTS-1:0]      rd_we_o,
  output logic [NUM_PORTS*5-1:0]    rd_addr_o,
  output logic [NUM_PORTS*XLEN-1:0] rd_data_o,
  output logic [CNT_W-1:0]          instret_o
);

  localparam int AW = NUM_PORTS * 5;
  localparam int DW = NUM_PORTS * XLEN;

  logic [1:0]           count_q, count_d;
  logic [NUM_PORTS-1:0] head_we_q, head_we_d, head_vld_q, head_vld_d;
  logic [NUM_PORTS-1:0] skid_we_q, skid_we_d, skid_vld_q, skid_vld_d;
  logic [AW-1:0]        head_addr_q, head_addr_d, skid_addr_q, skid_addr_d;
  logic [DW-1:0]        head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]     instret_q, instret_d;

  logic [NUM_PORTS-1:0] raw_we;
  logic [NUM_PORTS-1:0] cap_we;
  logic [CNT_W-1:0]     retire_cnt;
  logic                 push;
  logic                 pop;

  // Sanitised enables are stored, so later stalls never re-evaluate them.
  always_comb begin
    raw_we = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      raw_we[k] = rd_we_i[k] & slot_vld_i[k] & (rd_addr_i[5*k +: 5] != 5'd0);
    end
  end

  // Within one beat the highest-indexed slot is the youngest and wins a same-rd race.
  always_comb begin
    cap_we = raw_we;
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int k = j + 1; k < NUM_PORTS; k++) begin
        if (raw_we[j] && raw_we[k] && (rd_addr_i[5*j +: 5] == rd_addr_i[5*k +: 5])) begin
          cap_we[j] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    retire_cnt = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (head_vld_q[k]) begin
        retire_cnt = retire_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid_o = (count_q != 2'd0);
  assign in_ready_o  = (count_q != 2'd2) & rst_i;
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & ~rf_stall_i & ~flush_i & rst_i;

  assign rd_we_o   = pop ? head_we_q : '0;
  assign rd_addr_o = out_valid_o ? head_addr_q : '0;
  assign rd_data_o = out_valid_o ? head_data_q : '0;
  assign instret_o = instret_q;

  always_comb begin
    count_d     = count_q;
    head_we_d   = head_we_q;
    head_vld_d  = head_vld_q;
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    skid_we_d   = skid_we_q;
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    instret_d   = instret_q;

    if (pop) begin
      instret_d = instret_q + retire_cnt;
    end

    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_we_d   = cap_we;
            head_vld_d  = slot_vld_i;
            head_addr_d = rd_addr_i;
            head_data_d = rd_data_i;
          end else begin
            skid_we_d   = cap_we;
            skid_vld_d  = slot_vld_i;
            skid_addr_d = rd_addr_i;
            skid_data_d = rd_data_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_we_d   = skid_we_q;
          head_vld_d  = skid_vld_q;
          head_addr_d = skid_addr_q;
          head_data_d = skid_data_q;
          count_d     = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_we_d   = cap_we;
            head_vld_d  = slot_vld_i;
            head_addr_d = rd_addr_i;
            head_data_d = rd_data_i;
          end else begin
            head_we_d   = skid_we_q;
            head_vld_d  = skid_vld_q;
            head_addr_d = skid_addr_q;
            head_data_d = skid_data_q;
            skid_we_d   = cap_we;
            skid_vld_d  = slot_vld_i;
            skid_addr_d = rd_addr_i;
            skid_data_d = rd_data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q     <= 2'd0;
      head_we_q   <= '0;
      head_vld_q  <= '0;
      head_addr_q <= '0;
      head_data_q <= '0;
      skid_we_q   <= '0;
      skid_vld_q  <= '0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      instret_q   <= '0;
    end else begin
      count_q     <= count_d;
      head_we_q   <= head_we_d;
      head_vld_q  <= head_vld_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
      skid_we_q   <= skid_we_d;
      skid_vld_q  <= skid_vld_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      instret_q   <= instret_d;
    end
  end

endmodule

// File: tb/tb_writeback_stage_mp.sv
// tb/tb_writeback_stage_mp.sv - bench for writeback_stage_mp
// Two-slot instance with a 4-bit retire counter so wrap-around is reachable.
module tb_writeback_stage_mp;

  localparam int XLEN = 32;
  localparam int NP   = 2;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, rf_stall, out_valid;
  logic [NP-1:0]   slot_vld, rd_we, we_o;
  logic [NP*5-1:0] rd_addr, addr_o;
  logic [NP*XLEN-1:0] rd_data, data_o;
  logic [CW-1:0]   instret;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  we;
    logic [1:0]  vld;
    logic [9:0]  addr;
    logic [63:0] data;
  } beat_t;

  beat_t mq[$];
  int    m_instret = 0;

  always #5 clk = ~clk;

  writeback_stage_mp #(.XLEN(XLEN), .NUM_PORTS(NP), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .slot_vld_i(slot_vld), .rd_we_i(rd_we),
    .rd_addr_i(rd_addr), .rd_data_i(rd_data), .rf_stall_i(rf_stall),
    .out_valid_o(out_valid), .rd_we_o(we_o), .rd_addr_o(addr_o),
    .rd_data_o(data_o), .instret_o(instret)
  );

  // A register write happens only for a live slot that names a real register
  // and is not overwritten by a younger slot of the same beat.
  function automatic logic [1:0] exp_we(input logic [1:0] we, input logic [1:0] vld,
                                        input logic [9:0] addr);
    logic [1:0] r;
    logic [4:0] a0;
    logic [4:0] a1;
    a0 = addr[4:0];
    a1 = addr[9:5];
    r[0] = we[0] && vld[0] && (a0 != 5'd0);
    r[1] = we[1] && vld[1] && (a1 != 5'd0);
    if (r[0] && r[1] && a0 == a1) r[0] = 1'b0;
    return r;
  endfunction

  // Advance the reference model by one clock using the inputs now applied.
  task automatic tick();
    bit    rdy;
    beat_t b;
    rdy = (mq.size() != 2) && rst_n;
    if (!rst_n) begin
      mq.delete();
      m_instret = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && !rf_stall) begin
        m_instret = (m_instret + $countones(mq[0].vld)) % 16;
        void'(mq.pop_front());
      end
      if (in_valid && rdy) begin
        b.we   = exp_we(rd_we, slot_vld, rd_addr);
        b.vld  = slot_vld;
        b.addr = rd_addr;
        b.data = rd_data;
        mq.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] vld, input logic [1:0] we,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    in_valid = v;
    slot_vld = vld;
    rd_we    = we;
    rd_addr  = {a1, a0};
    rd_data  = {d1, d0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; rf_stall = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
    checks++; if (we_o !== 2'b00) begin errors++; $display("FAIL reset_we: got %b expected 00", we_o); end
    checks++; if (addr_o !== 10'd0 || data_o !== 64'd0) begin errors++; $display("FAIL reset_addr_data: got %h %h expected 0", addr_o, data_o); end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    drive(1'b1, 2'b11, 2'b11, 5'd5, 5'd6, 32'hAAAA_0001, 32'hBBBB_0002);
    tick();
    drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    #1;
    checks++; if (we_o !== 2'b11) begin errors++; $display("FAIL single_we: got %b expected 11", we_o); end
    checks++; if (addr_o !== {5'd6, 5'd5}) begin errors++; $display("FAIL single_addr: got %h expected %h", addr_o, {5'd6, 5'd5}); end
    checks++; if (data_o !== 64'hBBBB_0002_AAAA_0001) begin errors++; $display("FAIL single_data: got %h expected bbbb0002aaaa0001", data_o); end
    tick();
    #1;
    checks++; if (instret !== 4'd2) begin errors++; $display("FAIL single_instret: got %0d expected 2", instret); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    rf_stall = 1'b1;
    drive(1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 32'hA0, 32'hA1);
    tick();
    drive(1'b1, 2'b11, 2'b11, 5'd3, 5'd4, 32'hB0, 32'hB1);
    #1;
    checks++; if (we_o !== 2'b00 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stalled: got we=%b v=%b expected we=00 v=1", we_o, out_valid); end
    tick();
    drive(1'b1, 2'b11, 2'b11, 5'd5, 5'd6, 32'hC0, 32'hC1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    tick();
    rf_stall = 1'b0;
    #1;
    checks++; if (we_o !== 2'b11 || addr_o !== {5'd2, 5'd1}) begin errors++; $display("FAIL bp_drain_a: got we=%b addr=%h expected 11 %h", we_o, addr_o, {5'd2, 5'd1}); end
    tick();
    #1;
    checks++; if (in_ready !== 1'b1 || addr_o !== {5'd4, 5'd3}) begin errors++; $display("FAIL bp_drain_b: got rdy=%b addr=%h expected 1 %h", in_ready, addr_o, {5'd4, 5'd3}); end
    tick();
    drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    #1;
    checks++; if (addr_o !== {5'd6, 5'd5} || we_o !== 2'b11) begin errors++; $display("FAIL bp_drain_c: got addr=%h we=%b expected %h 11", addr_o, we_o, {5'd6, 5'd5}); end
    tick();
    #1;
    checks++; if (instret !== 4'(m_instret) || out_valid !== 1'b0) begin errors++; $display("FAIL bp_instret: got %0d v=%b expected %0d v=0", instret, out_valid, m_instret); end
  endtask

  task automatic test_sanitise();
    drive(1'b1, 2'b11, 2'b11, 5'd0, 5'd7, 32'h1, 32'h2);
    tick();
    drive(1'b1, 2'b11, 2'b11, 5'd9, 5'd9, 32'h11, 32'h22);
    #1;
    checks++; if (we_o !== 2'b10) begin errors++; $display("FAIL san_x0: got %b expected 10", we_o); end
    tick();
    drive(1'b1, 2'b01, 2'b11, 5'd3, 5'd4, 32'h5, 32'h6);
    #1;
    checks++; if (we_o !== 2'b10 || data_o[63:32] !== 32'h22) begin errors++; $display("FAIL san_same_rd: got we=%b d1=%h expected 10 22", we_o, data_o[63:32]); end
    tick();
    drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    #1;
    checks++; if (we_o !== 2'b01) begin errors++; $display("FAIL san_not_valid: got %b expected 01", we_o); end
    tick();
  endtask

  task automatic test_flush();
    int saved;
    rf_stall = 1'b1;
    drive(1'b1, 2'b11, 2'b11, 5'd10, 5'd11, 32'hD0, 32'hD1);
    tick();
    drive(1'b1, 2'b11, 2'b11, 5'd12, 5'd13, 32'hE0, 32'hE1);
    tick();
    drive(1'b1, 2'b11, 2'b11, 5'd14, 5'd15, 32'hF0, 32'hF1);
    flush = 1'b1;
    rf_stall = 1'b0;
    saved = m_instret;
    #1;
    checks++; if (we_o !== 2'b00) begin errors++; $display("FAIL flush_no_we: got %b expected 00", we_o); end
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    #1;
    checks++; if (out_valid !== 1'b0 || instret !== 4'(saved)) begin errors++; $display("FAIL flush_state: got v=%b ir=%0d expected 0 %0d", out_valid, instret, saved); end
    drive(1'b1, 2'b01, 2'b01, 5'd8, 5'd0, 32'h1234, 32'h0);
    tick();
    drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    #1;
    checks++; if (we_o !== 2'b01 || data_o[31:0] !== 32'h1234) begin errors++; $display("FAIL flush_after: got we=%b d0=%h expected 01 1234", we_o, data_o[31:0]); end
    tick();
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 2'b01, 2'b01, 5'd1, 5'd0, 32'(i), 32'd0);
      tick();
    end
    drive(1'b1, 2'b11, 2'b11, 5'd2, 5'd3, 32'h7, 32'h8);
    tick();
    drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    #1;
    checks++; if (instret !== 4'd15) begin errors++; $display("FAIL wrap_preload: got %0d expected 15", instret); end
    tick();
    #1;
    checks++; if (instret !== 4'd1) begin errors++; $display("FAIL wrap_value: got %0d expected 1", instret); end
  endtask

  task automatic test_reset_mid();
    rf_stall = 1'b1;
    drive(1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2);
    tick();
    drive(1'b1, 2'b11, 2'b11, 5'd3, 5'd4, 32'h3, 32'h4);
    tick();
    drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    rf_stall = 1'b0;
    rst_n = 1'b0;
    tick();
    #1;
    checks++; if (out_valid !== 1'b0 || we_o !== 2'b00) begin errors++; $display("FAIL rstmid_out: got v=%b we=%b expected 0 00", out_valid, we_o); end
    checks++; if (instret !== 4'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state: got ir=%0d rdy=%b expected 0 0", instret, in_ready); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_release: got rdy=%b v=%b expected 1 0", in_ready, out_valid); end
  endtask

  task automatic test_random();
    logic [1:0]  e_we;
    logic [9:0]  e_addr;
    logic [63:0] e_data;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom);
      rf_stall = ($urandom_range(0, 9) < 4);
      flush    = ($urandom_range(0, 19) == 0);
      #1;
      e_we   = (mq.size() != 0 && !rf_stall && !flush) ? mq[0].we : 2'b00;
      e_addr = (mq.size() != 0) ? mq[0].addr : 10'd0;
      e_data = (mq.size() != 0) ? mq[0].data : 64'd0;
      checks++; if (in_ready !== (mq.size() != 2)) begin errors++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, in_ready, mq.size() != 2); end
      checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, out_valid, mq.size() != 0); end
      checks++; if (we_o !== e_we) begin errors++; $display("FAIL rnd_we c=%0d: got %b expected %b", c, we_o, e_we); end
      checks++; if (addr_o !== e_addr || data_o !== e_data) begin errors++; $display("FAIL rnd_head c=%0d: got %h %h expected %h %h", c, addr_o, data_o, e_addr, e_data); end
      checks++; if (instret !== 4'(m_instret)) begin errors++; $display("FAIL rnd_instret c=%0d: got %0d expected %0d", c, instret, m_instret); end
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; rf_stall = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_sanitise();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
